// File: rtl/sysarray_pkg.sv
// Shared defaults and layout helper for the systolic matrix multiplier.
package sysarray_pkg;

  localparam int W_DEF = 32;  // element width
  localparam int N_DEF = 4;   // array dimension

  // Bit offset of element (i,j) inside the flattened result vector.
  function automatic int c_off(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/sysarray_pe.sv
// One processing element: multiply-accumulate with registered operand forwarding.
module sysarray_pe import sysarray_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic [W-1:0] acc
);

  // Product wraps to W bits; unsigned.
  logic [W-1:0] prod;
  assign prod = a_in * b_in;

  // Forward operands one hop; clear loads this edge's product, else accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr)     acc <= prod;
      else if (en) acc <= acc + prod;
    end
  end

endmodule

// File: rtl/sysarray.sv
// n x n output-stationary systolic array computing C = A*B, one k-step per cycle.
module sysarray import sysarray_pkg::*; #(
  parameter int N = W_DEF - 1,
  parameter int n = N_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           flg,
  input  logic [(N+1)*n-1:0]   arr1,
  input  logic [(N+1)*n-1:0]   arr2,
  output logic [(N+1)*n*n-1:0] c,
  output logic                 done
);

  localparam int W    = N + 1;
  localparam int CW   = $clog2(3 * n) + 1;
  localparam logic [CW-1:0] LAST = CW'(3 * n - 3);  // step of final accumulate
  localparam logic [CW-1:0] SAT  = CW'(3 * n - 2);  // idle / saturated
  localparam logic [CW-1:0] NLIM = CW'(n);

  // cnt holds the step number the next edge will process.
  logic          start, active, feed;
  logic [CW-1:0] cnt, step;

  assign start  = (flg == 7'd0);
  assign step   = start ? '0 : cnt;
  assign active = start || (cnt < SAT);
  assign feed   = active && (step < NLIM);

  // Step counter and done flag; done wins over start only at n==1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= SAT;
      done <= 1'b0;
    end else begin
      if (start)          cnt <= CW'(1);
      else if (cnt < SAT) cnt <= cnt + 1'b1;
      if (active && step == LAST) done <= 1'b1;
      else if (start)             done <= 1'b0;
    end
  end

  // Injected operands: zero outside the feed window, so idle ignores inputs.
  logic [n-1:0][W-1:0] ina, inb, ea, eb;

  for (genvar r = 0; r < n; r++) begin : g_in
    assign ina[r] = feed ? arr1[r*W +: W] : '0;
    assign inb[r] = feed ? arr2[r*W +: W] : '0;

    if (r == 0) begin : g_noskew
      assign ea[r] = ina[r];
      assign eb[r] = inb[r];
    end else begin : g_skew
      logic [r-1:0][W-1:0] da, db;
      // Delay row r of A and column r of B by r cycles; start flushes stale stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          da <= '0;
          db <= '0;
        end else begin
          da[0] <= ina[r];
          db[0] <= inb[r];
          for (int t = 1; t < r; t++) begin
            da[t] <= start ? '0 : da[t-1];
            db[t] <= start ? '0 : db[t-1];
          end
        end
      end
      assign ea[r] = da[r-1];
      assign eb[r] = db[r-1];
    end
  end

  // PE operand inputs; on a start edge only PE(0,0) sees live data.
  logic [n-1:0][n-1:0][W-1:0] ai, bi;

  for (genvar i = 0; i < n; i++) begin : g_row
    for (genvar j = 0; j < n; j++) begin : g_col
      logic [W-1:0] ao, bo;

      if (j == 0) begin : g_ael
        assign ai[i][0] = (start && i != 0) ? '0 : ea[i];
      end
      if (i == 0) begin : g_bel
        assign bi[0][j] = (start && j != 0) ? '0 : eb[j];
      end

      sysarray_pe #(.W(W)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (active),
        .a_in  (ai[i][j]),
        .b_in  (bi[i][j]),
        .a_out (ao),
        .b_out (bo),
        .acc   (c[c_off(i, j, n, W) +: W])
      );

      if (j < n - 1) begin : g_afwd
        assign ai[i][j+1] = start ? '0 : ao;
      end else begin : g_atail
        logic [W-1:0] a_unused;
        assign a_unused = ao;
      end
      if (i < n - 1) begin : g_bfwd
        assign bi[i+1][j] = start ? '0 : bo;
      end else begin : g_btail
        logic [W-1:0] b_unused;
        assign b_unused = bo;
      end
    end
  end

endmodule

// File: tb/tb_sysarray.sv
// Scoreboard bench for sysarray: driver pushes expected products, monitor checks on done.
module tb_sysarray;

  localparam int W    = 32;
  localparam int NN   = 4;
  localparam int LAST = 3 * NN - 3;
  localparam int TOT  = W * NN * NN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      flg = 7'd1;
  logic [W*NN-1:0] arr1 = '0, arr2 = '0;
  logic [TOT-1:0]  c;
  logic            done;

  sysarray #(.N(W-1), .n(NN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flg   (flg),
    .arr1  (arr1),
    .arr2  (arr2),
    .c     (c),
    .done  (done)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, edges = 0;

  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    logic [TOT-1:0] cv;
    int             edge_no;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [W-1:0] ma[NN][NN], mb[NN][NN];

  // Reference: plain matrix product modulo 2^W.
  function automatic logic [TOT-1:0] model();
    logic [TOT-1:0] r;
    logic [W-1:0]   s;
    r = '0;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++) begin
        s = '0;
        for (int k = 0; k < NN; k++) s = s + ma[i][k] * mb[k][j];
        r[(i*NN+j)*W +: W] = s;
      end
    return r;
  endfunction

  task automatic check1(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_c(input string nm, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int k = NN*NN-1; k >= 0; k--)
      if (act[k*W +: W] !== exp[k*W +: W]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: C[%0d][%0d] got %0d expected %0d", nm, bad/NN, bad%NN,
               act[bad*W +: W], exp[bad*W +: W]);
    end
  endtask

  // Monitor: on done rising pop and compare; while done stays high c must hold.
  logic           pdone = 1'b0;
  logic [TOT-1:0] held = '0;
  always @(negedge clk) begin
    if (done && !pdone) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no result", edges);
      end else begin
        e = sb.pop_front();
        check_c("result", c, e.cv);
        check1("done_edge", edges, e.edge_no);
        held <= e.cv;
      end
    end else if (done && pdone) begin
      check_c("hold", c, held);
    end
    pdone <= done;
  end

  task automatic fill_rand();
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < NN; k++) begin
        ma[i][k] = $urandom;
        mb[i][k] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      end
  endtask

  // Drive one run from its start edge; stop_at>=0 returns before that step (abort).
  task automatic run(input bit stdmode, input int stop_at);
    int sn;
    if (stop_at < 0) sb.push_back('{model(), edges + 1 + LAST});
    for (int s = 0; s <= LAST + 2; s++) begin
      if (stop_at >= 0 && s == stop_at) return;
      if (s < NN) begin
        flg = 7'(s);
        for (int i = 0; i < NN; i++) begin
          arr1[i*W +: W] = ma[i][s];
          arr2[i*W +: W] = mb[s][i];
        end
      end else begin
        sn = (s <= 7) ? s : s - 1;
        flg  = stdmode ? 7'(sn) : 7'($urandom_range(1, 127));
        arr1 = {$urandom, $urandom, $urandom, $urandom};
        arr2 = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      if (s == 0) check1("done_clr_on_start", done, 0);
      if (stdmode && s == 10) begin
        check1("std_done_11th", done, 1);
        check1("std_c00", c[0*W +: W], 90);
        check1("std_c01", c[1*W +: W], 202);
        check1("std_c03", c[3*W +: W], 426);
        check1("std_c10", c[4*W +: W], 100);
        check1("std_c33", c[15*W +: W], 600);
      end
    end
  endtask

  task automatic idle(input int cyc);
    for (int t = 0; t < cyc; t++) begin
      flg  = 7'($urandom_range(1, 127));
      arr1 = {$urandom, $urandom, $urandom, $urandom};
      arr2 = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check_c("idle_c", c, '0);
      check1("idle_done", done, 0);
    end
  endtask

  // Async reset between edges: outputs clear with no clock edge.
  task automatic async_reset(input string tag);
    int e0;
    flg = 7'd1;
    #2;
    e0 = edges;
    rst_n = 1'b0;
    #1;
    check_c({tag, "_c"}, c, '0);
    check1({tag, "_done"}, done, 0);
    check1({tag, "_noedge"}, edges, e0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_c("reset_c", c, '0);
    check1("reset_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    idle(20);

    // Standard product.
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < NN; k++) begin
        ma[i][k] = W'(4*k + i + 1);
        mb[k][i] = W'(k + 4*i + 1);
      end
    run(1, -1);

    // Identity times M.
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < NN; k++) begin
        ma[i][k] = (i == k) ? W'(1) : W'(0);
        mb[i][k] = W'(4*i + k + 1);
      end
    run(0, -1);

    // Overflow: every product and sum wraps.
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < NN; k++) begin
        ma[i][k] = '1;
        mb[i][k] = '1;
      end
    run(0, -1);
    check1("ovf_c33", c[15*W +: W], 4);

    // Restart at s==5, then at s==2, then while done is high.
    fill_rand(); run(0, 5);
    fill_rand(); run(0, 2);
    fill_rand(); run(0, -1);
    fill_rand(); run(0, -1);

    // Async reset mid-run, then a clean run.
    fill_rand(); run(0, 5);
    async_reset("rst_mid");
    idle(4);
    fill_rand(); run(0, -1);

    // Async reset while done is high.
    async_reset("rst_done");
    idle(4);

    for (int r = 0; r < 5; r++) begin
      fill_rand();
      if (r == 2) run(0, 7);
      fill_rand();
      run(0, -1);
    end

    @(negedge clk); #1;
    check1("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysarray.md
SYSARRAY -- requirements
Module: sysarray

Interface
REQ-001 Parameter N, default 31: element MSB index; element width W = N+1 = 32 bits.
REQ-002 Parameter n, default 4: array dimension; n x n processing elements (PEs).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flg  input  7  step index from the driver; the value 0 marks a start.
REQ-006 arr1  input  W*n  slice i [i*W +: W] = A[i][k], column k of A, where k is the current step.
REQ-007 arr2  input  W*n  slice j [j*W +: W] = B[k][j], row k of B, where k is the current step.
REQ-008 c  output  W*n*n  result matrix C = A*B; C[i][j] at bits [(i*n+j)*W +: W].
REQ-009 done  output  1  high while c holds a complete result.

Function
REQ-010 Every rising edge with flg==0 SHALL start a computation:
- all accumulators are cleared;
- the internal step counter s is set to 0;
- arr1/arr2 are sampled as step k=0.
REQ-011 After a start, s SHALL increment by 1 every edge, independent of later flg values.
- flg values other than 0, including repeated values, have no effect.
REQ-012 arr1/arr2 SHALL be sampled as step k only on edges where s==k, for k = 0..n-1.
- When s>=n, zeros are injected into the array.
REQ-013 Input skew: A row i SHALL be delayed i cycles before entering PE(i,0); B column j SHALL be delayed j cycles before entering PE(0,j).
REQ-014 Operand flow: A operands SHALL move one PE right per cycle; B operands SHALL move one PE down per cycle.
REQ-015 Timing: PE(i,j) SHALL add A[i][k]*B[k][j] to its accumulator on the edge where s == k+i+j.
REQ-016 Arithmetic is unsigned. The product and the sum SHALL each be truncated to W bits, wrapping modulo 2^W.
REQ-017 The last accumulate happens at s == 3n-3 (9 for n=4). done SHALL go high on that edge.
REQ-018 done SHALL stay high, and c SHALL hold its value, until the next start edge or reset.
REQ-019 c SHALL be driven directly from the accumulators.
- Before done rises, c shows partial sums; this is legal and is not checked.
REQ-020 A start edge during an active computation SHALL abort it:
- accumulators are cleared;
- the pipeline is flushed, and the new step-0 data enters;
- done is cleared on that edge.
REQ-021 After done rises, s SHALL saturate and no further accumulation SHALL occur until the next start.

Reset
REQ-022 With rst_n low, the following SHALL clear immediately, without waiting for a clock:
- accumulators, operand registers and skew registers to 0;
- done to 0;
- s to the idle/saturated state.
REQ-023 After reset and before the first start, the block SHALL be idle with c==0 and done==0, ignoring arr1/arr2.

Structure
REQ-024 A shared package SHALL hold the defaults for W and n and the function that computes the c bit offset of element (i,j).
REQ-025 A single sub-module sysarray_pe SHALL implement one PE:
- registered A and B pass-through;
- multiply-accumulate;
- synchronous clear;
- async reset.
REQ-026 The top level SHALL generate n*n instances of sysarray_pe, plus the skew registers, the step counter and the done logic.

Verification
REQ-027 Standard product: feed steps 0..3 with flg=0..3.
- arr1 step k slices = {4k+1, 4k+2, 4k+3, 4k+4}; arr2 step k slices = {k+1, k+5, k+9, k+13}.
- Then run flg=4..9, with flg=7 held for two edges.
- Required: done=1 after the 11th edge; C[0][0]=90, C[0][1]=202, C[0][3]=426, C[1][0]=100, C[3][3]=600.
REQ-028 Identity: A = I, B = M with M[k][j] = 4k+j+1.
- Required: c equals M exactly; done rises on the edge where s==9.
REQ-029 Overflow: all inputs 0xFFFFFFFF.
- Required: every C[i][j] = 4 mod 2^32 = 4.
REQ-030 Restart: assert flg==0 again at s==5 of the first run, then a new data set.
- Required: done drops on that edge; the final c reflects only the second data set.
REQ-031 Async reset: pull rst_n low mid-run, between edges.
- Required: c==0 and done==0 immediately, with no clock edge.
- Required: the next start then computes correctly.
REQ-032 Idle: after reset, toggle arr1/arr2 with flg!=0.
- Required: c remains 0 and done remains 0.
